minority_voter_array: RTL and testbench

Parametrised, filtered successor of the single-bit XAPP197 minority voter for TMR output pads. A bank of `WIDTH` independent channels compares each primary leg with its two reference legs. A channel tristates its OBUF only after a persistent minority condition, and re-enables it only after a persistent agreement. Sticky per-channel fault flags and an optional saturating fault-event counter are reported to slow control. It sits between the triplicated output logic and the OBUF T ports.

---
 rtl/minority_voter_pkg.sv | 24 ++
 rtl/minority_voter_array_channel.sv | 128 ++++++++++++
 rtl/minority_voter_array.sv | 89 ++++++++
 tb/tb_minority_voter_array.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/minority_voter_pkg.sv
// Shared types and helpers for the minority voter array: channel FSM states,
// run-counter width and the per-channel leg classification.
package minority_voter_pkg;

    localparam int MV_CNT_W = 8;

    typedef enum logic [1:0] {
        DRIVE   = 2'd0,
        SUSPECT = 2'd1,
        OFF     = 2'd2,
        RECOVER = 2'd3
    } mv_state_t;

    // Returns {minority, agree}; both low means the two references disagree.
    function automatic logic [1:0] mv_classify(input logic primary, input logic ref_a,
                                               input logic ref_b);
        logic minority;
        logic agree;
        minority = (ref_a == ref_b) && (primary != ref_a);
        agree    = (ref_a == ref_b) && (primary == ref_a);
        return {minority, agree};
    endfunction

endpackage

// File: rtl/minority_voter_array_channel.sv
// One voted output channel: filter FSM with run counter, registered tristate,
// sticky fault flag and a combinational OFF-entry pulse for the event counter.
module minority_voter_channel
    import minority_voter_pkg::*;
#(
    parameter int FILTER_DEPTH  = 3,
    parameter int RELEASE_DEPTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      enable_i,
    input  logic      primary_i,
    input  logic      reference_a_i,
    input  logic      reference_b_i,
    input  logic      fault_clear_i,
    output logic      tristate_o,
    output logic      fault_o,
    output logic      entry_o,
    output mv_state_t state_o
);

    localparam logic [MV_CNT_W-1:0] FD = MV_CNT_W'(FILTER_DEPTH);
    localparam logic [MV_CNT_W-1:0] RD = MV_CNT_W'(RELEASE_DEPTH);

    mv_state_t           state_q, state_d;
    logic [MV_CNT_W-1:0] cnt_q, cnt_d;
    logic [MV_CNT_W-1:0] cnt_inc;
    logic                tri_q, tri_d;
    logic                fault_q, fault_d;
    logic                entry;
    logic                minority;
    logic                agree;

    always_comb begin
        {minority, agree} = mv_classify(primary_i, reference_a_i, reference_b_i);
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + MV_CNT_W'(1);
        entry   = 1'b0;

        if (!enable_i) begin
            state_d = DRIVE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DRIVE: begin
                    if (minority) begin
                        if (FD == MV_CNT_W'(1)) begin
                            state_d = OFF;
                            cnt_d   = '0;
                            entry   = 1'b1;
                        end else begin
                            state_d = SUSPECT;
                            cnt_d   = MV_CNT_W'(1);
                        end
                    end
                end
                SUSPECT: begin
                    // Undecided cycles fall through: state and count are held.
                    if (minority) begin
                        if (cnt_inc == FD) begin
                            state_d = OFF;
                            cnt_d   = '0;
                            entry   = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (agree) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end
                end
                OFF: begin
                    if (agree) begin
                        if (RD == MV_CNT_W'(1)) begin
                            state_d = DRIVE;
                            cnt_d   = '0;
                        end else begin
                            state_d = RECOVER;
                            cnt_d   = MV_CNT_W'(1);
                        end
                    end
                end
                RECOVER: begin
                    if (agree) begin
                        if (cnt_inc == RD) begin
                            state_d = DRIVE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (minority) begin
                        state_d = OFF;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            endcase
        end

        // An entering channel keeps its flag even when a clear lands on the same edge.
        fault_d = entry | (fault_q & ~fault_clear_i);
        tri_d   = (state_d == OFF) || (state_d == RECOVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DRIVE;
            cnt_q   <= '0;
            tri_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tri_q   <= tri_d;
            fault_q <= fault_d;
        end
    end

    assign tristate_o = tri_q;
    assign fault_o    = fault_q;
    assign entry_o    = entry;
    assign state_o    = state_q;

endmodule

// File: rtl/minority_voter_array.sv
// Bank of WIDTH minority-voter channels plus the slow-control fault-event counter.
// The counter is built only when MINORITY_VOTER_ERRCNT_EN is defined.
module minority_voter_array
    import minority_voter_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int FILTER_DEPTH  = 3,
    parameter int RELEASE_DEPTH = 16,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] primary_i,
    input  logic [WIDTH-1:0] reference_a_i,
    input  logic [WIDTH-1:0] reference_b_i,
    input  logic             fault_clear_i,
    output logic [WIDTH-1:0] driver_tristate_o,
    output logic [WIDTH-1:0] fault_o,
    output logic [CNT_W-1:0] fault_count_o
);

    logic [WIDTH-1:0] entry;
    mv_state_t        ch_state [WIDTH];

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        minority_voter_channel #(
            .FILTER_DEPTH (FILTER_DEPTH),
            .RELEASE_DEPTH(RELEASE_DEPTH)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .enable_i     (enable_i),
            .primary_i    (primary_i[g]),
            .reference_a_i(reference_a_i[g]),
            .reference_b_i(reference_b_i[g]),
            .fault_clear_i(fault_clear_i),
            .tristate_o   (driver_tristate_o[g]),
            .fault_o      (fault_o[g]),
            .entry_o      (entry[g]),
            .state_o      (ch_state[g])
        );
    end

`ifdef MINORITY_VOTER_ERRCNT_EN
    localparam int PW = $clog2(WIDTH + 1);
    localparam int SW = CNT_W + PW;
    localparam logic [SW-1:0] SAT = SW'({CNT_W{1'b1}});

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_base;
    logic [PW-1:0]    pop;
    logic [SW-1:0]    sum;

    // The sum is widened so a large popcount cannot wrap before saturation.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(entry[i]);
        end
        count_base = fault_clear_i ? '0 : count_q;
        sum        = SW'(count_base) + SW'(pop);
        count_d    = (sum > SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fault_count_o = count_q;
`else
    logic unused_entry;
    assign unused_entry  = ^entry;
    assign fault_count_o = '0;
`endif

    logic unused_state;
    always_comb begin
        unused_state = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            unused_state = unused_state ^ (^ch_state[i]);
        end
    end

endmodule

// File: tb/tb_minority_voter_array.sv
// Directed-vector bench for minority_voter_array: driver pushes expected outputs
// into a queue, a negedge monitor pops and compares them.
module tb_minority_voter_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic [7:0]  primary_i;
    logic [7:0]  reference_a_i;
    logic [7:0]  reference_b_i;
    logic        fault_clear_i;
    logic [7:0]  driver_tristate_o;
    logic [7:0]  fault_o;
    logic [15:0] fault_count_o;

    minority_voter_array #(
        .WIDTH        (8),
        .FILTER_DEPTH (3),
        .RELEASE_DEPTH(16),
        .CNT_W        (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable_i         (enable_i),
        .primary_i        (primary_i),
        .reference_a_i    (reference_a_i),
        .reference_b_i    (reference_b_i),
        .fault_clear_i    (fault_clear_i),
        .driver_tristate_o(driver_tristate_o),
        .fault_o          (fault_o),
        .fault_count_o    (fault_count_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  t;
        logic [7:0]  f;
        logic [15:0] c;
    } exp_s;

    exp_s  exp_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [7:0] mdl_fault = 8'h00;
    int         mdl_count = 0;

    function automatic int popcnt(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [15:0] exp_count(input int c);
`ifdef MINORITY_VOTER_ERRCNT_EN
        return c[15:0];
`else
        return (c == -1) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    always @(negedge clk) begin
        exp_s  e;
        string nm;
        while (exp_q.size() > 0 && int'(exp_q[0].due) < cyc) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", nm, e.due, cyc);
        end
        if (exp_q.size() > 0 && int'(exp_q[0].due) == cyc) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            checks++;
            if (driver_tristate_o !== e.t || fault_o !== e.f || fault_count_o !== e.c) begin
                errors++;
                $display("FAIL %s: got T=%h fault=%h count=%h, want T=%h fault=%h count=%h",
                         nm, driver_tristate_o, fault_o, fault_count_o, e.t, e.f, e.c);
            end
        end
    end

    // ---------------- driver ----------------
    // Applies one cycle of inputs; ent is the hand-computed set of channels entering
    // OFF on the coming edge, t_exp the hand-computed tristate after that edge.
    task automatic drive(input string nm, input bit chk, input logic r, input logic en,
                         input logic clr, input logic [7:0] p, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] ent, input logic [7:0] t_exp);
        exp_s e;
        rst           = r;
        enable_i      = en;
        fault_clear_i = clr;
        primary_i     = p;
        reference_a_i = a;
        reference_b_i = b;
        if (r) begin
            mdl_fault = 8'h00;
            mdl_count = 0;
        end else begin
            mdl_fault = clr ? ent : (mdl_fault | ent);
            mdl_count = clr ? popcnt(ent) : mdl_count + popcnt(ent);
            if (mdl_count > 65535) mdl_count = 65535;
        end
        if (chk) begin
            e.due = 32'(cyc + 1);
            e.t   = t_exp;
            e.f   = mdl_fault;
            e.c   = exp_count(mdl_count);
            exp_q.push_back(e);
            nm_q.push_back(nm);
        end
        @(posedge clk);
        #1;
    endtask

    // Refs at 0: channels with p=1 see minority, the rest agree.
    task automatic vec(input string nm, input logic [7:0] p, input logic [7:0] ent,
                       input logic [7:0] t_exp);
        drive(nm, 1'b1, 1'b0, 1'b1, 1'b0, p, 8'h00, 8'h00, ent, t_exp);
    endtask

    task automatic bypass(input string nm, input bit chk);
        drive(nm, chk, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; enable_i = 1'b1; fault_clear_i = 1'b0;
        primary_i = '0; reference_a_i = '0; reference_b_i = '0;
        @(posedge clk);
        #1;

        drive("reset", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        drive("reset_hold", 1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00);

        // channel 2 minority for 3 edges
        vec("ch2_min1", 8'h04, 8'h00, 8'h00);
        vec("ch2_min2", 8'h04, 8'h00, 8'h00);
        vec("ch2_min3_off", 8'h04, 8'h04, 8'h04);
        vec("ch2_off_stays", 8'h04, 8'h00, 8'h04);

        // 15 agrees, then minority: back to OFF, not a new event
        for (int i = 0; i < 15; i++) vec("ch2_recover15", 8'h00, 8'h00, 8'h04);
        vec("ch2_recover_to_off", 8'h04, 8'h00, 8'h04);
        for (int i = 0; i < 15; i++) vec("ch2_release_wait", 8'h00, 8'h00, 8'h04);
        vec("ch2_release16", 8'h00, 8'h00, 8'h00);

        // 2-cycle pulse never trips
        vec("ch3_pulse1", 8'h08, 8'h00, 8'h00);
        vec("ch3_pulse2", 8'h08, 8'h00, 8'h00);
        vec("ch3_pulse_end", 8'h00, 8'h00, 8'h00);
        vec("ch3_restart1", 8'h08, 8'h00, 8'h00);
        vec("ch3_restart2", 8'h08, 8'h00, 8'h00);
        vec("ch3_restart_end", 8'h00, 8'h00, 8'h00);

        // undecided cycles on channel 5 hold the run
        vec("ch5_m1", 8'h20, 8'h00, 8'h00);
        drive("ch5_u1", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
        drive("ch5_u2", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
        vec("ch5_m2", 8'h20, 8'h00, 8'h00);
        drive("ch5_u3", 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00);
        vec("ch5_m3_off", 8'h20, 8'h20, 8'h20);

        // bypass while OFF
        drive("bypass_off", 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00);
        drive("bypass_min", 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);

        // reset in the middle of a SUSPECT run
        vec("ch1_s1", 8'h02, 8'h00, 8'h00);
        vec("ch1_s2", 8'h02, 8'h00, 8'h00);
        drive("rst_mid_suspect", 1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
        vec("after_rst1", 8'h02, 8'h00, 8'h00);
        vec("after_rst2", 8'h02, 8'h00, 8'h00);
        vec("after_rst_agree", 8'h00, 8'h00, 8'h00);

        // clear coinciding with entries on channels 6 and 7
        vec("ch0_m1", 8'h01, 8'h00, 8'h00);
        vec("ch0_m2", 8'h01, 8'h00, 8'h00);
        vec("ch0_off", 8'h01, 8'h01, 8'h01);
        bypass("bypass_ch0", 1'b1);
        vec("ch67_m1", 8'hC0, 8'h00, 8'h00);
        vec("ch67_m2", 8'hC0, 8'h00, 8'h00);
        drive("clear_with_entry", 1'b1, 1'b0, 1'b1, 1'b1, 8'hC0, 8'h00, 8'h00, 8'hC0, 8'hC0);
        bypass("bypass_ch67", 1'b1);
        drive("clear_only", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // bring the counter to 65533, then overflow it with 8 entries
        for (int r = 0; r < 8191; r++) begin
            vec("sat_round_m1", 8'hFF, 8'h00, 8'h00);
            vec("sat_round_m2", 8'hFF, 8'h00, 8'h00);
            drive("sat_round_off", (r == 0), 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF);
            bypass("sat_round_bypass", (r == 8190));
        end
        vec("sat_5_m1", 8'h1F, 8'h00, 8'h00);
        vec("sat_5_m2", 8'h1F, 8'h00, 8'h00);
        vec("sat_5_off_65533", 8'h1F, 8'h1F, 8'h1F);
        bypass("sat_5_bypass", 1'b1);
        vec("sat_8_m1", 8'hFF, 8'h00, 8'h00);
        vec("sat_8_m2", 8'hFF, 8'h00, 8'h00);
        vec("sat_8_saturate", 8'hFF, 8'hFF, 8'hFF);
        bypass("sat_8_bypass", 1'b1);
        vec("sat_hold_m1", 8'h01, 8'h00, 8'h00);
        vec("sat_hold_m2", 8'h01, 8'h00, 8'h00);
        vec("sat_hold_off", 8'h01, 8'h01, 8'h01);
        bypass("sat_hold_bypass", 1'b1);

        // clear where channels 1 and 3 enter
        vec("clr2_m1", 8'h0A, 8'h00, 8'h00);
        vec("clr2_m2", 8'h0A, 8'h00, 8'h00);
        drive("clr2_entry", 1'b1, 1'b0, 1'b1, 1'b1, 8'h0A, 8'h00, 8'h00, 8'h0A, 8'h0A);
        vec("clr2_after", 8'h0A, 8'h00, 8'h0A);

        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
